ifc_seq_driver: RTL and testbench

Initiator-side sequencer for the X/Y/Q/Z interface view: it drives IFC_X, IFC_Y and IFC_Q into a combinational responder entity and samples that entity's IFC_Z output. It accepts one command over a valid/ready handshake and runs N beats, stepping X down by Q and Y up by 1 each beat. It accumulates the sampled Z values and returns the sum and the last Z over a second valid/ready handshake. It sits in the parent entity next to the responder instance and replaces the hand-written X/Y update process.

---
 rtl/ifc_seq_driver.sv | 139 +++++++++++++
 tb/tb_ifc_seq_driver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifc_seq_driver.sv
// rtl/ifc_seq_driver.sv - X/Y/Q initiator sequencer with Z accumulation; IFC_SEQ_DRIVER_SAT_EN saturates X/Y stepping
module ifc_seq_driver #(
   parameter int XW  = 16,
   parameter int QW  = 8,
   parameter int ZW  = 8,
   parameter int CW  = 8,
   parameter int LAT = 0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [XW-1:0]    CMD_X,
   input  logic [XW-1:0]    CMD_Y,
   input  logic [QW-1:0]    CMD_Q,
   input  logic [CW-1:0]    CMD_N,
   output logic [XW-1:0]    IFC_X,
   output logic [XW-1:0]    IFC_Y,
   output logic [QW-1:0]    IFC_Q,
   input  logic [ZW-1:0]    IFC_Z,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [ZW+CW-1:0] RES_SUM,
   output logic [ZW-1:0]    RES_LAST,
   output logic             BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

   // The per-beat hold counter only needs to reach LAT, which is at most 3.
   localparam logic [1:0] LAT_W = 2'(LAT);

   state_t            state;
   state_t            state_nxt;
   logic [ZW+CW-1:0]  sum;
   logic [ZW-1:0]     last;
   logic [CW-1:0]     beats;
   logic [1:0]        wait_cnt;
   logic              cmd_fire;
   logic              beat_end;
   logic [XW-1:0]     q_ext;
   logic [XW-1:0]     x_step;
   logic [XW-1:0]     y_step;

   assign RES_SUM  = sum;
   assign RES_LAST = last;

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      CMD_READY = 1'b0;
      RES_VALID = 1'b0;
      BUSY      = 1'b0;
      cmd_fire  = 1'b0;
      beat_end  = 1'b0;
      case (state)
         S_IDLE: begin
            CMD_READY = 1'b1;
            if (CMD_VALID) begin
               cmd_fire  = 1'b1;
               state_nxt = (CMD_N != '0) ? S_HOLD : S_DONE;
            end
         end
         S_HOLD: begin
            BUSY = 1'b1;
            if (wait_cnt == LAT_W) begin
               beat_end = 1'b1;
               if (beats == CW'(1)) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            BUSY      = 1'b1;
            RES_VALID = 1'b1;
            if (RES_READY) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Per-beat X/Y stepping; Q is zero-extended to the X width.
   always_comb begin
      q_ext = XW'(IFC_Q);
`ifdef IFC_SEQ_DRIVER_SAT_EN
      x_step = (q_ext > IFC_X) ? '0 : IFC_X - q_ext;
      y_step = (&IFC_Y) ? IFC_Y : IFC_Y + XW'(1);
`else
      x_step = IFC_X - q_ext;
      y_step = IFC_Y + XW'(1);
`endif
   end

   // Interface fields, beat/hold counters and the Z accumulator.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         IFC_X    <= '0;
         IFC_Y    <= '0;
         IFC_Q    <= '0;
         sum      <= '0;
         last     <= '0;
         beats    <= '0;
         wait_cnt <= '0;
      end else if (cmd_fire) begin
         IFC_X    <= CMD_X;
         IFC_Y    <= CMD_Y;
         IFC_Q    <= CMD_Q;
         sum      <= '0;
         last     <= '0;
         beats    <= CMD_N;
         wait_cnt <= '0;
      end else if (beat_end) begin
         // Z is taken straight from the responder on the edge closing the beat.
         sum      <= sum + (ZW+CW)'(IFC_Z);
         last     <= IFC_Z;
         beats    <= beats - CW'(1);
         wait_cnt <= '0;
         // The final beat leaves IFC_* at the values it was sampled with.
         if (beats > CW'(1)) begin
            IFC_X <= x_step;
            IFC_Y <= y_step;
         end
      end else if (state == S_HOLD) begin
         wait_cnt <= wait_cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_ifc_seq_driver.sv
// tb/tb_ifc_seq_driver.sv - self-checking bench for ifc_seq_driver at LAT=0 and LAT=2
module tb_ifc_seq_driver;

   logic        CLK;
   logic        rst_n;
   logic        cmd_valid;
   logic        res_ready;
   logic [15:0] cmd_x, cmd_y;
   logic [7:0]  cmd_q, cmd_n;
   logic        sel;

   logic        cv [2];
   logic        rr [2];
   logic        cr [2];
   logic [15:0] ix [2];
   logic [15:0] iy [2];
   logic [7:0]  iq [2];
   logic [7:0]  iz [2];
   logic        rv [2];
   logic [15:0] rs [2];
   logic [7:0]  rl [2];
   logic        bz [2];

   logic        m_cr, m_rv, m_bz;
   logic [15:0] m_ix, m_iy, m_rs;
   logic [7:0]  m_rl;
   logic [7:0]  p1, p2;

   int checks = 0;
   int errors = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] zf(input logic [15:0] x, input logic [15:0] y, input logic [7:0] q);
      logic [15:0] t;
      t = x + y - {8'h00, q};
      return t[7:0];
   endfunction

   // Responders: LAT=0 is purely combinational, LAT=2 has two register stages.
   assign iz[0] = zf(ix[0], iy[0], iq[0]);
   always_ff @(posedge CLK) begin
      p1 <= zf(ix[1], iy[1], iq[1]);
      p2 <= p1;
   end
   assign iz[1] = p2;

   assign cv[0] = cmd_valid & ~sel;
   assign cv[1] = cmd_valid & sel;
   assign rr[0] = res_ready & ~sel;
   assign rr[1] = res_ready & sel;

   always_comb begin
      m_cr = cr[sel];
      m_rv = rv[sel];
      m_bz = bz[sel];
      m_ix = ix[sel];
      m_iy = iy[sel];
      m_rs = rs[sel];
      m_rl = rl[sel];
   end

   ifc_seq_driver #(.XW(16), .QW(8), .ZW(8), .CW(8), .LAT(0)) dut0 (
      .CLK(CLK), .RST_N(rst_n), .CMD_VALID(cv[0]), .CMD_READY(cr[0]),
      .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_Q(cmd_q), .CMD_N(cmd_n),
      .IFC_X(ix[0]), .IFC_Y(iy[0]), .IFC_Q(iq[0]), .IFC_Z(iz[0]),
      .RES_VALID(rv[0]), .RES_READY(rr[0]), .RES_SUM(rs[0]), .RES_LAST(rl[0]), .BUSY(bz[0])
   );

   ifc_seq_driver #(.XW(16), .QW(8), .ZW(8), .CW(8), .LAT(2)) dut2 (
      .CLK(CLK), .RST_N(rst_n), .CMD_VALID(cv[1]), .CMD_READY(cr[1]),
      .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_Q(cmd_q), .CMD_N(cmd_n),
      .IFC_X(ix[1]), .IFC_Y(iy[1]), .IFC_Q(iq[1]), .IFC_Z(iz[1]),
      .RES_VALID(rv[1]), .RES_READY(rr[1]), .RES_SUM(rs[1]), .RES_LAST(rl[1]), .BUSY(bz[1])
   );

   typedef struct {
      logic        s;
      logic [15:0] x, y;
      logic [7:0]  q, n;
      logic [15:0] esum;
      logic [7:0]  elast;
      logic [15:0] exf, eyf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic [7:0]  last;
   } res_t;

   vec_t vecs [9];
   res_t sb [$];

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] xstep(input logic [15:0] x, input logic [7:0] q);
`ifdef IFC_SEQ_DRIVER_SAT_EN
      return ({8'h00, q} > x) ? 16'h0000 : x - {8'h00, q};
`else
      return x - {8'h00, q};
`endif
   endfunction

   function automatic logic [15:0] ystep(input logic [15:0] y);
`ifdef IFC_SEQ_DRIVER_SAT_EN
      return (y == 16'hFFFF) ? y : y + 16'd1;
`else
      return y + 16'd1;
`endif
   endfunction

   task automatic set_vec(input int i, input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] q, input logic [7:0] n);
      logic [15:0] cx, cy, acc;
      logic [7:0]  z, lz;
      cx = x; cy = y; acc = '0; lz = '0;
      for (int b = 0; b < int'(n); b++) begin
         z   = zf(cx, cy, q);
         acc = acc + {8'h00, z};
         lz  = z;
         if (b < int'(n) - 1) begin
            cx = xstep(cx, q);
            cy = ystep(cy);
         end
      end
      vecs[i] = '{s, x, y, q, n, acc, lz, cx, cy};
   endtask

   task automatic take_result(input string name);
      res_ready = 1'b1;
      tick;
      chk({name, "_rv_drop"}, m_rv, 1'b0);
      chk({name, "_cr_back"}, m_cr, 1'b1);
      res_ready = 1'b0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      res_t e, g;
      int   cyc;
      int   lat;
      v   = vecs[i];
      sel = v.s;
      lat = v.s ? 2 : 0;
      cyc = 0;
      while (!m_cr && cyc < 50) begin
         tick;
         cyc++;
      end
      chk($sformatf("v%0d_ready", i), m_cr, 1'b1);
      cmd_x = v.x; cmd_y = v.y; cmd_q = v.q; cmd_n = v.n;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      sb.push_back('{v.esum, v.elast});
      cyc = 1;
      while (!m_rv && cyc < 2000) begin
         tick;
         cyc++;
      end
      chk($sformatf("v%0d_latency", i), cyc, int'(v.n) * (lat + 1) + 1);
      chk($sformatf("v%0d_final_x", i), m_ix, v.exf);
      chk($sformatf("v%0d_final_y", i), m_iy, v.eyf);
      if (m_rv && sb.size() > 0) begin
         e = sb.pop_front();
         g = '{m_rs, m_rl};
         chk($sformatf("v%0d_sum", i), g.sum, e.sum);
         chk($sformatf("v%0d_last", i), g.last, e.last);
      end
      take_result($sformatf("v%0d", i));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic        bad;
      logic [15:0] exp_x1;

      rst_n = 1'b0; cmd_valid = 1'b1; res_ready = 1'b0; sel = 1'b0;
      cmd_x = 16'h1234; cmd_y = 16'h5678; cmd_q = 8'h9A; cmd_n = 8'd3;

      set_vec(0, 1'b0, 16'd17,    16'd21,    8'd3,   8'd3);
      set_vec(1, 1'b0, 16'd1000,  16'd50,    8'd7,   8'd10);
      set_vec(2, 1'b0, 16'd5,     16'hFFFE,  8'd1,   8'd4);
      set_vec(3, 1'b0, 16'd0,     16'd0,     8'd0,   8'd1);
      set_vec(4, 1'b0, 16'd300,   16'd9,     8'd255, 8'd255);
      set_vec(5, 1'b0, 16'd2,     16'd0,     8'd5,   8'd2);
      set_vec(6, 1'b1, 16'd17,    16'd21,    8'd3,   8'd3);
      set_vec(7, 1'b1, 16'd40000, 16'd123,   8'd200, 8'd6);
      set_vec(8, 1'b1, 16'd9,     16'd9,     8'd9,   8'd0);

      // Reset with a command offered: nothing is accepted.
      tick; tick;
      chk("rst_cmd_ready", m_cr, 1'b1);
      chk("rst_res_valid", m_rv, 1'b0);
      chk("rst_busy", m_bz, 1'b0);
      chk("rst_busy_lat2", bz[1], 1'b0);
      chk("rst_ifc_x", m_ix, 16'h0);
      chk("rst_ifc_y", m_iy, 16'h0);
      chk("rst_ifc_q", iq[0], 8'h0);
      chk("rst_sum", m_rs, 16'h0);
      chk("rst_last", m_rl, 8'h0);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      tick;
      chk("rst_not_accepted", m_cr, 1'b1);

      // Table of commands, scoreboarded.
      for (int i = 0; i < 9; i++) begin
         run_vec(i);
      end

      // Basic run, LAT=0: cycle-by-cycle X/Y trace.
      sel = 1'b0;
      cmd_x = 16'd17; cmd_y = 16'd21; cmd_q = 8'd3; cmd_n = 8'd3;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("basic_x0", m_ix, 16'd17); chk("basic_y0", m_iy, 16'd21);
      tick;
      chk("basic_x1", m_ix, 16'd14); chk("basic_y1", m_iy, 16'd22);
      tick;
      chk("basic_x2", m_ix, 16'd11); chk("basic_y2", m_iy, 16'd23);
      chk("basic_rv_early", m_rv, 1'b0);
      tick;
      chk("basic_rv_k4", m_rv, 1'b1);
      chk("basic_sum", m_rs, 16'd99);
      chk("basic_last", m_rl, 8'd31);
      take_result("basic");

      // Latency LAT=2: each X value held three cycles, result at k+10.
      sel = 1'b1;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("lat2_x_b%0d_c%0d", b, c), m_ix, 16'd17 - 16'(3 * b));
            chk($sformatf("lat2_rv_b%0d_c%0d", b, c), m_rv, 1'b0);
            tick;
         end
      end
      chk("lat2_rv_k10", m_rv, 1'b1);
      chk("lat2_sum", m_rs, 16'd99);
      take_result("lat2");

      // Zero beats: result right after accept, accumulator cleared.
      sel = 1'b0;
      cmd_x = 16'h0ABC; cmd_y = 16'd5; cmd_q = 8'd1; cmd_n = 8'd0;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("zero_rv_k1", m_rv, 1'b1);
      chk("zero_sum", m_rs, 16'd0);
      chk("zero_last", m_rl, 8'd0);
      chk("zero_ifc_x", m_ix, 16'h0ABC);
      take_result("zero");

      // Backpressure: result held, new command waits for the result handshake.
      cmd_x = 16'd17; cmd_y = 16'd21; cmd_q = 8'd3; cmd_n = 8'd3;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      tick; tick; tick;
      cmd_x = 16'd100; cmd_y = 16'd1; cmd_q = 8'd1; cmd_n = 8'd1;
      cmd_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_rv_%0d", c), m_rv, 1'b1);
         chk($sformatf("bp_sum_%0d", c), m_rs, 16'd99);
         chk($sformatf("bp_last_%0d", c), m_rl, 8'd31);
         chk($sformatf("bp_cr_%0d", c), m_cr, 1'b0);
         chk($sformatf("bp_x_%0d", c), m_ix, 16'd11);
         tick;
      end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk("bp_rv_drop", m_rv, 1'b0);
      chk("bp_cr_back", m_cr, 1'b1);
      tick;
      cmd_valid = 1'b0;
      chk("bp_second_busy", m_bz, 1'b1);
      chk("bp_second_x", m_ix, 16'd100);
      tick;
      chk("bp_second_rv", m_rv, 1'b1);
      chk("bp_second_sum", m_rs, 16'd100);
      take_result("bp2");

      // Wrap or saturate of X on the first step.
`ifdef IFC_SEQ_DRIVER_SAT_EN
      exp_x1 = 16'h0000;
`else
      exp_x1 = 16'hFFFD;
`endif
      cmd_x = 16'd2; cmd_y = 16'd0; cmd_q = 8'd5; cmd_n = 8'd2;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("wrap_x0", m_ix, 16'd2);
      tick;
      chk("wrap_x1", m_ix, exp_x1);
      tick;
      chk("wrap_rv", m_rv, 1'b1);
      take_result("wrap");

      // Reset in the middle of beat 1 on the LAT=2 instance.
      sel = 1'b1;
      cmd_x = 16'd17; cmd_y = 16'd21; cmd_q = 8'd3; cmd_n = 8'd3;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      tick; tick; tick; tick;
      chk("mid_pre_x", m_ix, 16'd14);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mid_cr", m_cr, 1'b1);
      chk("mid_busy", m_bz, 1'b0);
      chk("mid_ifc_x", m_ix, 16'h0);
      chk("mid_sum", m_rs, 16'h0);
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (m_rv !== 1'b0) bad = 1'b1;
         tick;
      end
      chk("mid_no_rv_pulse", bad, 1'b0);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
